control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Port list: clock, reset, stop, ir, mem_ready (MEM_WAIT_EN only), ctrl, alu_op, run, state. Clock and reset are listed first.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low; reset==0 at a rising edge forces the reset behaviour below.
REQ-004 stop  input  1  halt request, sampled every rising edge.
REQ-005 ir  input  32  instruction register contents; opcode=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
REQ-006 mem_ready  input  1  memory read complete; present only when MEM_WAIT_EN is defined.
REQ-007 ctrl  output  20  datapath strobes. Bit map, LSB first: 0 PCout, 1 PCin, 2 incPC, 3 MARin, 4 read, 5 MDRin, 6 MDRout, 7 IRin, 8 Yin, 9 Zin, 10 ZLowOut, 11 ZHighOut, 12 Gra, 13 Grb, 14 Grc, 15 Rin, 16 Rout, 17 Cout, 18 HIin, 19 LOin.
REQ-008 alu_op  output  5  ALU opcode; equals ir[31:27] in T4 and 5'b00000 otherwise.
REQ-009 run  output  1  1 while sequencing, 0 in RST and HALT.
REQ-010 state  output  4  current state encoding: RST=0, T0..T6=1..7, HALT=8.

Function
REQ-011 Moore machine: ctrl, alu_op, run and state are decoded from the registered state and ir only; no path from stop or mem_ready to any output.
REQ-012 Any strobe not listed for a state is 0.
REQ-013 Opcode set: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011, ADDI 01100, ANDI 01101, ORI 01110, MUL 01111, DIV 10000, NEG 10001, NOT 10010, NOP 11010, HALT 11011.
REQ-014 Any opcode not in REQ-013 executes as NOP.
REQ-015 RST: all ctrl bits 0; next state is T0.
REQ-016 T0: PCout, MARin, incPC, Zin are asserted.
REQ-017 T1: ZLowOut, PCin, read, MDRin are asserted.
REQ-018 T2: MDRout, IRin are asserted.
REQ-019 T3, binary and immediate ops (ADD..ORI): Grb, Rout, Yin are asserted.
REQ-020 T3, MUL/DIV: Gra, Rout, Yin are asserted.
REQ-021 T3, NEG/NOT: no strobes are asserted.
REQ-022 T4, binary ops (ADD..ROL): Grc, Rout, Zin are asserted.
REQ-023 T4, immediate ops (ADDI..ORI): Cout, Zin are asserted.
REQ-024 T4, MUL/DIV/NEG/NOT: Grb, Rout, Zin are asserted.
REQ-025 T5, ALU ops other than MUL/DIV: ZLowOut, Gra, Rin are asserted; next state is T0.
REQ-026 T5, MUL/DIV: ZLowOut, LOin are asserted; next state is T6.
REQ-027 T6: ZHighOut, HIin are asserted; next state is T0.
REQ-028 NOP in T3: next state is T0.
REQ-029 HALT opcode in T3: next state is HALT.
REQ-030 Latency: ALU ops take 6 cycles (T0-T5); MUL/DIV take 7; NOP takes 4.
REQ-031 stop is honoured only at instruction boundaries: if stop==1 at any edge, a pending-halt flag is set; whenever the next state would be T0 and the flag (or the current stop) is set, the next state is HALT instead. An in-flight instruction always completes.
REQ-032 HALT is absorbing: all ctrl bits 0, run=0; only reset exits it.

Reset
REQ-033 reset==0 at a rising edge sets state=RST and clears the pending-halt flag, including mid-instruction; no write strobe (Rin, HIin, LOin, PCin, IRin) is asserted in the following cycle.
REQ-034 The first rising edge with reset==1 moves RST to T0; run becomes 1 in that cycle.

Configuration
REQ-035 With MEM_WAIT_EN defined: the mem_ready input exists; T1 holds (outputs unchanged) until mem_ready==1 at an edge, then advances to T2.
REQ-036 With MEM_WAIT_EN defined, stop has no effect on a T1 wait.
REQ-037 Without MEM_WAIT_EN: the mem_ready port is absent; T1 always lasts exactly one cycle.

Verification
REQ-038 Reset held low for 3 edges, then released: state=0 and ctrl=0 while held; state=1 and ctrl bits {0,2,3,9} set on the first cycle after release.
REQ-039 ir=ADD (opcode 00011): state sequence 1,2,3,4,5,6,1; alu_op=00011 only in state 5; Rin asserted only in state 6.
REQ-040 ir=MUL: seven-state sequence ending in T6; LOin asserted in T5 and HIin in T6; Rin is never asserted.
REQ-041 stop pulsed for one cycle during T2 of ADDI: instruction completes through T5, then state=8 and run=0, held for 10+ cycles.
REQ-042 reset pulsed low during T4 of SUB: next state=0, no Rin; T0 follows.
REQ-043 MEM_WAIT_EN defined, mem_ready low for 4 cycles in T1: state stays 2 for 5 cycles with ctrl bits {1,4,5,10} constant, then T2.

Source files
------------

// File: rtl/control_sequencer.sv
// Hard-wired control sequencer: fetch (T0-T2), decode/execute (T3-T6) with a halt state.
// Optional MEM_WAIT_EN adds a mem_ready input that stretches T1 until the memory read completes.
module control_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        stop,
  input  logic [31:0] ir,
`ifdef MEM_WAIT_EN
  input  logic        mem_ready,
`endif
  output logic [19:0] ctrl,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam int unsigned PCOUT    = 0;
  localparam int unsigned PCIN     = 1;
  localparam int unsigned INCPC    = 2;
  localparam int unsigned MARIN    = 3;
  localparam int unsigned READ     = 4;
  localparam int unsigned MDRIN    = 5;
  localparam int unsigned MDROUT   = 6;
  localparam int unsigned IRIN     = 7;
  localparam int unsigned YIN      = 8;
  localparam int unsigned ZIN      = 9;
  localparam int unsigned ZLOWOUT  = 10;
  localparam int unsigned ZHIGHOUT = 11;
  localparam int unsigned GRA      = 12;
  localparam int unsigned GRB      = 13;
  localparam int unsigned GRC      = 14;
  localparam int unsigned RIN      = 15;
  localparam int unsigned ROUT     = 16;
  localparam int unsigned COUT     = 17;
  localparam int unsigned HIIN     = 18;
  localparam int unsigned LOIN     = 19;

  state_t      cur, nxt;
  logic        halt_pend;
  logic [4:0]  opcode;
  logic        is_bin, is_imm, is_muldiv, is_unary, is_halt, is_alu;
  logic        unused_ir;

  assign opcode    = ir[31:27];
  // Register fields are consumed by the datapath, not by the sequencer.
  assign unused_ir = ^ir[26:0];

  always_comb begin
    is_bin    = 1'b0;
    is_imm    = 1'b0;
    is_muldiv = 1'b0;
    is_unary  = 1'b0;
    is_halt   = 1'b0;
    case (opcode)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: is_bin    = 1'b1;
      5'b01100, 5'b01101, 5'b01110:           is_imm    = 1'b1;
      5'b01111, 5'b10000:                     is_muldiv = 1'b1;
      5'b10001, 5'b10010:                     is_unary  = 1'b1;
      5'b11011:                               is_halt   = 1'b1;
      default: ;
    endcase
  end

  assign is_alu = is_bin | is_imm | is_muldiv | is_unary;

  always_comb begin
    nxt = cur;
    case (cur)
      S_RST: nxt = S_T0;
      S_T0:  nxt = S_T1;
`ifdef MEM_WAIT_EN
      S_T1:  nxt = mem_ready ? S_T2 : S_T1;
`else
      S_T1:  nxt = S_T2;
`endif
      S_T2:  nxt = S_T3;
      S_T3: begin
        if (is_halt)     nxt = S_HALT;
        else if (is_alu) nxt = S_T4;
        else             nxt = S_T0;
      end
      S_T4:  nxt = S_T5;
      S_T5:  nxt = is_muldiv ? S_T6 : S_T0;
      S_T6:  nxt = S_T0;
      S_HALT: nxt = S_HALT;
      default: nxt = S_RST;
    endcase
    // Halt requests take effect only at an instruction boundary.
    if (nxt == S_T0 && (halt_pend || stop))
      nxt = S_HALT;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cur       <= S_RST;
      halt_pend <= 1'b0;
    end else begin
      cur       <= nxt;
      halt_pend <= (nxt == S_HALT) ? 1'b0 : (halt_pend | stop);
    end
  end

  always_comb begin
    ctrl   = '0;
    alu_op = '0;
    case (cur)
      S_T0: begin
        ctrl[PCOUT] = 1'b1;
        ctrl[MARIN] = 1'b1;
        ctrl[INCPC] = 1'b1;
        ctrl[ZIN]   = 1'b1;
      end
      S_T1: begin
        ctrl[ZLOWOUT] = 1'b1;
        ctrl[PCIN]    = 1'b1;
        ctrl[READ]    = 1'b1;
        ctrl[MDRIN]   = 1'b1;
      end
      S_T2: begin
        ctrl[MDROUT] = 1'b1;
        ctrl[IRIN]   = 1'b1;
      end
      S_T3: begin
        if (is_bin || is_imm) begin
          ctrl[GRB]  = 1'b1;
          ctrl[ROUT] = 1'b1;
          ctrl[YIN]  = 1'b1;
        end else if (is_muldiv) begin
          ctrl[GRA]  = 1'b1;
          ctrl[ROUT] = 1'b1;
          ctrl[YIN]  = 1'b1;
        end
      end
      S_T4: begin
        alu_op    = opcode;
        ctrl[ZIN] = 1'b1;
        if (is_bin) begin
          ctrl[GRC]  = 1'b1;
          ctrl[ROUT] = 1'b1;
        end else if (is_imm) begin
          ctrl[COUT] = 1'b1;
        end else begin
          ctrl[GRB]  = 1'b1;
          ctrl[ROUT] = 1'b1;
        end
      end
      S_T5: begin
        ctrl[ZLOWOUT] = 1'b1;
        if (is_muldiv) begin
          ctrl[LOIN] = 1'b1;
        end else begin
          ctrl[GRA] = 1'b1;
          ctrl[RIN] = 1'b1;
        end
      end
      S_T6: begin
        ctrl[ZHIGHOUT] = 1'b1;
        ctrl[HIIN]     = 1'b1;
      end
      default: ;
    endcase
  end

  assign run   = (cur != S_RST) && (cur != S_HALT);
  assign state = cur;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer; define MEM_WAIT_EN to also exercise the T1 memory wait.
module tb_control_sequencer;

  logic        clock;
  logic        reset;
  logic        stop;
  logic [31:0] ir;
  logic        mem_ready;
  logic [19:0] ctrl;
  logic [4:0]  alu_op;
  logic        run;
  logic [3:0]  state;

  int total = 0;
  int bad   = 0;

  localparam logic [19:0] C_T0    = 20'h0020D;
  localparam logic [19:0] C_T1    = 20'h00432;
  localparam logic [19:0] C_T2    = 20'h000C0;
  localparam logic [19:0] C_T3B   = 20'h12100;
  localparam logic [19:0] C_T3M   = 20'h11100;
  localparam logic [19:0] C_T4B   = 20'h14200;
  localparam logic [19:0] C_T4I   = 20'h20200;
  localparam logic [19:0] C_T4M   = 20'h12200;
  localparam logic [19:0] C_T5    = 20'h09400;
  localparam logic [19:0] C_T5M   = 20'h80400;
  localparam logic [19:0] C_T6    = 20'h40800;

  control_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .stop      (stop),
    .ir        (ir),
`ifdef MEM_WAIT_EN
    .mem_ready (mem_ready),
`endif
    .ctrl      (ctrl),
    .alu_op    (alu_op),
    .run       (run),
    .state     (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic step(input string tag, input logic [3:0] es, input logic [19:0] ec,
                      input logic [4:0] ea, input logic er);
    @(negedge clock);
    check({tag, ".state"}, 32'(state), 32'(es));
    check({tag, ".ctrl"},  32'(ctrl),  32'(ec));
    check({tag, ".alu"},   32'(alu_op), 32'(ea));
    check({tag, ".run"},   32'(run),   32'(er));
  endtask

  task automatic fetch(input string tag);
    step({tag, ".t1"}, 4'd2, C_T1, 5'd0, 1'b1);
    step({tag, ".t2"}, 4'd3, C_T2, 5'd0, 1'b1);
  endtask

  initial begin
    reset = 1'b0; stop = 1'b0; mem_ready = 1'b1;
    ir = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};

    // Reset held for three edges
    for (int i = 0; i < 3; i++) step("rst_hold", 4'd0, 20'h0, 5'd0, 1'b0);
    reset = 1'b1;
    step("rst_rel", 4'd1, C_T0, 5'd0, 1'b1);

    // ADD
    fetch("add");
    step("add.t3", 4'd4, C_T3B, 5'd0, 1'b1);
    step("add.t4", 4'd5, C_T4B, 5'b00011, 1'b1);
    step("add.t5", 4'd6, C_T5, 5'd0, 1'b1);
    step("add.t0", 4'd1, C_T0, 5'd0, 1'b1);

    // MUL
    ir = {5'b01111, 27'd0};
    fetch("mul");
    step("mul.t3", 4'd4, C_T3M, 5'd0, 1'b1);
    step("mul.t4", 4'd5, C_T4M, 5'b01111, 1'b1);
    step("mul.t5", 4'd6, C_T5M, 5'd0, 1'b1);
    step("mul.t6", 4'd7, C_T6, 5'd0, 1'b1);
    step("mul.t0", 4'd1, C_T0, 5'd0, 1'b1);

    // NOP and an undefined opcode both return to T0 after T3
    ir = {5'b11010, 27'd0};
    fetch("nop");
    step("nop.t3", 4'd4, 20'h0, 5'd0, 1'b1);
    step("nop.t0", 4'd1, C_T0, 5'd0, 1'b1);
    ir = {5'b00000, 27'h5A5A5A5};
    fetch("undef");
    step("undef.t3", 4'd4, 20'h0, 5'd0, 1'b1);
    step("undef.t0", 4'd1, C_T0, 5'd0, 1'b1);

    // NEG
    ir = {5'b10001, 27'd0};
    fetch("neg");
    step("neg.t3", 4'd4, 20'h0, 5'd0, 1'b1);
    step("neg.t4", 4'd5, C_T4M, 5'b10001, 1'b1);
    step("neg.t5", 4'd6, C_T5, 5'd0, 1'b1);
    step("neg.t0", 4'd1, C_T0, 5'd0, 1'b1);

    // DIV latency
    ir = {5'b10000, 27'd0};
    fetch("div");
    step("div.t3", 4'd4, C_T3M, 5'd0, 1'b1);
    step("div.t4", 4'd5, C_T4M, 5'b10000, 1'b1);
    step("div.t5", 4'd6, C_T5M, 5'd0, 1'b1);
    step("div.t6", 4'd7, C_T6, 5'd0, 1'b1);
    step("div.t0", 4'd1, C_T0, 5'd0, 1'b1);

    // SUB interrupted by reset in T4
    ir = {5'b00100, 27'd0};
    fetch("sub");
    step("sub.t3", 4'd4, C_T3B, 5'd0, 1'b1);
    step("sub.t4", 4'd5, C_T4B, 5'b00100, 1'b1);
    reset = 1'b0;
    step("sub.rst", 4'd0, 20'h0, 5'd0, 1'b0);
    reset = 1'b1;
    step("sub.t0", 4'd1, C_T0, 5'd0, 1'b1);

    // ADDI with stop pulsed during T2
    ir = {5'b01100, 27'd0};
    fetch("addi");
    stop = 1'b1;
    step("addi.t3", 4'd4, C_T3B, 5'd0, 1'b1);
    stop = 1'b0;
    step("addi.t4", 4'd5, C_T4I, 5'b01100, 1'b1);
    step("addi.t5", 4'd6, C_T5, 5'd0, 1'b1);
    for (int i = 0; i < 10; i++) step("addi.halt", 4'd8, 20'h0, 5'd0, 1'b0);

    // Stop seen on the T5 edge itself halts at the boundary
    reset = 1'b0;
    step("r2", 4'd0, 20'h0, 5'd0, 1'b0);
    reset = 1'b1;
    ir = {5'b00011, 27'd0};
    step("or.t0", 4'd1, C_T0, 5'd0, 1'b1);
    ir = {5'b00110, 27'd0};
    fetch("or");
    step("or.t3", 4'd4, C_T3B, 5'd0, 1'b1);
    step("or.t4", 4'd5, C_T4B, 5'b00110, 1'b1);
    step("or.t5", 4'd6, C_T5, 5'd0, 1'b1);
    stop = 1'b1;
    step("or.halt", 4'd8, 20'h0, 5'd0, 1'b0);
    stop = 1'b0;

    // HALT opcode
    reset = 1'b0;
    step("r3", 4'd0, 20'h0, 5'd0, 1'b0);
    reset = 1'b1;
    ir = {5'b11011, 27'd0};
    step("hlt.t0", 4'd1, C_T0, 5'd0, 1'b1);
    fetch("hlt");
    step("hlt.t3", 4'd4, 20'h0, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) step("hlt.halt", 4'd8, 20'h0, 5'd0, 1'b0);

`ifdef MEM_WAIT_EN
    reset = 1'b0;
    step("r4", 4'd0, 20'h0, 5'd0, 1'b0);
    reset = 1'b1;
    ir = {5'b00011, 27'd0};
    step("mw.t0", 4'd1, C_T0, 5'd0, 1'b1);
    mem_ready = 1'b0;
    step("mw.t1", 4'd2, C_T1, 5'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) stop = 1'b1;
      step("mw.wait", 4'd2, C_T1, 5'd0, 1'b1);
      stop = 1'b0;
    end
    mem_ready = 1'b1;
    step("mw.t2", 4'd3, C_T2, 5'd0, 1'b1);
    step("mw.t3", 4'd4, C_T3B, 5'd0, 1'b1);
    step("mw.t4", 4'd5, C_T4B, 5'b00011, 1'b1);
    step("mw.t5", 4'd6, C_T5, 5'd0, 1'b1);
    step("mw.halt", 4'd8, 20'h0, 5'd0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
